// File: rtl/alu_seq_if.sv
// alu_seq_if -- bundles the signals of the issue/writeback sequencer.
//
// Signal groups:
//   instruction : in_valid, in_ready, in_op[2:0], in_rd[1:0], in_rs1[1:0],
//                 in_rs2[1:0], in_imm_sel, in_imm[3:0]
//   alu bus     : alu_en, alu_opcode[7:0], alu_in_1[3:0], alu_in_2[3:0],
//                 alu_out[3:0]
//   result      : res_valid, res_rd[1:0], res_data[3:0]
//                 res_zero (only when ALU_SEQ_ZFLAG_EN is defined)
//
// Modports:
//   master : the sequencer (drives in_ready, the ALU bus and the result).
//   slave  : its environment (upstream issuer, ALU and result consumer).
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. The issuer holds every in_* field stable while
// in_valid=1 and in_ready=0. in_ready never depends on in_valid.
// Optional feature macro: ALU_SEQ_ZFLAG_EN.

interface alu_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic       in_imm_sel;
    logic [3:0] in_imm;

    logic       alu_en;
    logic [7:0] alu_opcode;
    logic [3:0] alu_in_1;
    logic [3:0] alu_in_2;
    logic [3:0] alu_out;

    logic       res_valid;
    logic [1:0] res_rd;
    logic [3:0] res_data;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       res_zero;
`endif

    modport master (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
        input  alu_out,
        output in_ready,
        output alu_en, alu_opcode, alu_in_1, alu_in_2,
        output res_valid, res_rd, res_data
`ifdef ALU_SEQ_ZFLAG_EN
        , output res_zero
`endif
    );

    modport slave (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
        output alu_out,
        input  in_ready,
        input  alu_en, alu_opcode, alu_in_1, alu_in_2,
        input  res_valid, res_rd, res_data
`ifdef ALU_SEQ_ZFLAG_EN
        , input res_zero
`endif
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- issue/writeback sequencer in front of the 4-bit ALU.
//
// Accepts one instruction per handshake, reads operands from a 4x4-bit
// register file (or an immediate for in_1), pulses the ALU enable for one
// cycle, captures the ALU's registered result the cycle after and writes it
// back, flagging it on a one-cycle result strobe.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : alu_seq_if.master (instruction, ALU bus and result groups)
//   dbg_state : current FSM state (0=IDLE, 1=ISSUE, 2=WB)
//
// Optional feature: define ALU_SEQ_ZFLAG_EN to add bus.res_zero, registered
// at writeback as (alu_out == 0) and held until the next writeback.

module alu_seq (
    input  logic            clk,
    input  logic            rst_n,
    alu_seq_if.master       bus,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] rf [4];
    logic [1:0] rd_q;
    logic       accept;

    logic       alu_en_q;
    logic [7:0] alu_opcode_q;
    logic [3:0] alu_in_1_q;
    logic [3:0] alu_in_2_q;
    logic       res_valid_q;
    logic [1:0] res_rd_q;
    logic [3:0] res_data_q;

    assign accept = (state == IDLE) && bus.in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed three-cycle loop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue side. The register file is read directly at the accept edge, so
    // an instruction accepted in the res_valid cycle already sees the value
    // written at the preceding WB edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en_q     <= 1'b0;
            alu_opcode_q <= 8'd0;
            alu_in_1_q   <= 4'd0;
            alu_in_2_q   <= 4'd0;
            rd_q         <= 2'd0;
        end else begin
            alu_en_q <= accept;
            if (accept) begin
                alu_opcode_q <= {5'b0, bus.in_op};
                alu_in_1_q   <= bus.in_imm_sel ? bus.in_imm : rf[bus.in_rs1];
                alu_in_2_q   <= rf[bus.in_rs2];
                rd_q         <= bus.in_rd;
            end
        end
    end

    // Writeback side: alu_out is valid during WB and taken unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 4'd0;
            end
            res_valid_q <= 1'b0;
            res_rd_q    <= 2'd0;
            res_data_q  <= 4'd0;
        end else begin
            res_valid_q <= (state == WB);
            if (state == WB) begin
                rf[rd_q]   <= bus.alu_out;
                res_rd_q   <= rd_q;
                res_data_q <= bus.alu_out;
            end
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    logic res_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero_q <= 1'b0;
        end else if (state == WB) begin
            res_zero_q <= (bus.alu_out == 4'd0);
        end
    end

    assign bus.res_zero = res_zero_q;
`endif

    assign bus.in_ready   = (state == IDLE);
    assign bus.alu_en     = alu_en_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_in_1   = alu_in_1_q;
    assign bus.alu_in_2   = alu_in_2_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_rd     = res_rd_q;
    assign bus.res_data   = res_data_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed bench for alu_seq with a behavioural 4-bit ALU.
// The ALU stand-in registers its result on an edge where alu_en=1:
//   0 pass in_1, 1 add, 2 sub, 3 not in_1, 4 and, 5 or, 6 xor, 7 in_1<<2.

module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    logic [3:0] alu_q = 4'd0;
    int         en_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    alu_seq_if bus ();

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(logic [7:0] opc, logic [3:0] a, logic [3:0] b);
        case (opc[2:0])
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return ~a;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return {a[1:0], 2'b00};
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.alu_en) begin
            alu_q  <= alu_model(bus.alu_opcode, bus.alu_in_1, bus.alu_in_2);
            en_cnt <= en_cnt + 1;
        end
    end
    assign bus.alu_out = alu_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while in IDLE; the instruction is taken at
    // the following rising edge.
    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic sel, input logic [3:0] imm);
        bus.in_op      = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm_sel = sel;
        bus.in_imm     = imm;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Full instruction: issue-cycle operands, WB-cycle quiet, result cycle.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic sel, input logic [3:0] imm,
                             input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] eres);
        check("ready_idle", {7'd0, bus.in_ready}, 8'd1);
        drive(op, rd, rs1, rs2, sel, imm);
        exp_q.push_back({4'd0, eres});
        @(negedge clk);
        check("issue_en", {7'd0, bus.alu_en}, 8'd1);
        check("issue_opcode", bus.alu_opcode, {5'd0, op});
        check("issue_in1", {4'd0, bus.alu_in_1}, {4'd0, e1});
        check("issue_in2", {4'd0, bus.alu_in_2}, {4'd0, e2});
        check("issue_resv", {7'd0, bus.res_valid}, 8'd0);
        check("issue_ready", {7'd0, bus.in_ready}, 8'd0);
        @(negedge clk);
        check("wb_en", {7'd0, bus.alu_en}, 8'd0);
        check("wb_resv", {7'd0, bus.res_valid}, 8'd0);
        @(negedge clk);
        check("res_valid", {7'd0, bus.res_valid}, 8'd1);
        check("res_rd", {6'd0, bus.res_rd}, {6'd0, rd});
        if (exp_q.size() > 0) check("res_data", {4'd0, bus.res_data}, exp_q.pop_front());
        else check("res_queue", 8'd0, 8'd1);
        check("res_ready", {7'd0, bus.in_ready}, 8'd1);
    endtask

    logic [2:0] p_op  [3] = '{3'd5, 3'd4, 3'd0};
    logic [1:0] p_rs1 [3] = '{2'd1, 2'd3, 2'd0};
    logic [1:0] p_rs2 [3] = '{2'd2, 2'd1, 2'd0};
    logic       p_sel [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] p_imm [3] = '{4'd0, 4'd0, 4'd9};
    logic [3:0] p_in1 [3] = '{4'd5, 4'd7, 4'd9};
    logic [3:0] p_res [3] = '{4'd7, 4'd5, 4'd9};

    initial begin
        int en_before;
        bus.in_valid   = 1'b0;
        bus.in_op      = 3'd0;
        bus.in_rd      = 2'd0;
        bus.in_rs1     = 2'd0;
        bus.in_rs2     = 2'd0;
        bus.in_imm_sel = 1'b0;
        bus.in_imm     = 4'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {7'd0, bus.in_ready}, 8'd1);
        check("rst_en", {7'd0, bus.alu_en}, 8'd0);
        check("rst_opcode", bus.alu_opcode, 8'd0);
        check("rst_in1", {4'd0, bus.alu_in_1}, 8'd0);
        check("rst_in2", {4'd0, bus.alu_in_2}, 8'd0);
        check("rst_resv", {7'd0, bus.res_valid}, 8'd0);
        check("rst_rd", {6'd0, bus.res_rd}, 8'd0);
        check("rst_data", {4'd0, bus.res_data}, 8'd0);
        check("rst_state", {6'd0, dbg_state}, 8'd0);
`ifdef ALU_SEQ_ZFLAG_EN
        check("rst_zero", {7'd0, bus.res_zero}, 8'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // r1 <= 5, r2 <= 3, r3 <= 5+3
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 4'd5, 4'd0, 4'd5);
        run_instr(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 4'd3, 4'd3, 4'd0, 4'd3);
        run_instr(3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 4'd5, 4'd3, 4'd8);
        // 3-5 wraps to E; dependent op issued in the res_valid cycle
        run_instr(3'd2, 2'd0, 2'd2, 2'd1, 1'b0, 4'd0, 4'd3, 4'd5, 4'hE);
        run_instr(3'd3, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'hE, 4'hE, 4'h1);

        // in_valid held high across three instructions into r3
        en_before = en_cnt;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("hold_ready1", {7'd0, bus.in_ready}, 8'd1);
            bus.in_op      = p_op[k];
            bus.in_rd      = 2'd3;
            bus.in_rs1     = p_rs1[k];
            bus.in_rs2     = p_rs2[k];
            bus.in_imm_sel = p_sel[k];
            bus.in_imm     = p_imm[k];
            @(negedge clk);
            check("hold_ready0a", {7'd0, bus.in_ready}, 8'd0);
            check("hold_in1", {4'd0, bus.alu_in_1}, {4'd0, p_in1[k]});
            @(negedge clk);
            check("hold_ready0b", {7'd0, bus.in_ready}, 8'd0);
            @(negedge clk);
            check("hold_resv", {7'd0, bus.res_valid}, 8'd1);
            check("hold_data", {4'd0, bus.res_data}, {4'd0, p_res[k]});
        end
        bus.in_valid = 1'b0;
        check("hold_issues", 8'(en_cnt - en_before), 8'd3);

        // 5^5 = 0 into r0, then r2<<2 = C into r1
        run_instr(3'd6, 2'd0, 2'd1, 2'd1, 1'b0, 4'd0, 4'd5, 4'd5, 4'd0);
`ifdef ALU_SEQ_ZFLAG_EN
        check("zero_set", {7'd0, bus.res_zero}, 8'd1);
`endif
        run_instr(3'd7, 2'd1, 2'd2, 2'd2, 1'b0, 4'd0, 4'd3, 4'd3, 4'hC);
`ifdef ALU_SEQ_ZFLAG_EN
        check("zero_clr", {7'd0, bus.res_zero}, 8'd0);
`endif

        // Reset during ISSUE: instruction dropped, r3 (was 9) cleared
        drive(3'd0, 2'd3, 2'd0, 2'd0, 1'b1, 4'd7);
        @(negedge clk);
        check("pre_rst_en", {7'd0, bus.alu_en}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("arst_en", {7'd0, bus.alu_en}, 8'd0);
        check("arst_opcode", bus.alu_opcode, 8'd0);
        check("arst_in1", {4'd0, bus.alu_in_1}, 8'd0);
        check("arst_ready", {7'd0, bus.in_ready}, 8'd1);
        check("arst_state", {6'd0, dbg_state}, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("arst_noresv", {7'd0, bus.res_valid}, 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_noresv", {7'd0, bus.res_valid}, 8'd0);
        run_instr(3'd0, 2'd0, 2'd3, 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
